// File: rtl/shift_cmp_seq.sv
// rtl/shift_cmp_seq.sv - multi-cycle shift (1 bit/cycle) and single-cycle set-less-than unit
// Valid/ready on both sides; one request in flight, result held in DONE until accepted.
module shift_cmp_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [1:0]        i_func,
  input  logic              i_sig,
  input  logic              i_athi,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_result
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_acc;
  logic [SHAMT_W-1:0]   r_cnt;
  logic                 r_left;
  logic                 r_fill;
  logic                 r_valid;
  logic [DATA_W-1:0]    r_result;

  logic [SHAMT_W-1:0]   w_shamt;
  logic [DATA_W-1:0]    w_cmp_a;
  logic [DATA_W-1:0]    w_cmp_b;
  logic                 w_lt;
  logic [DATA_W-1:0]    w_acc_next;

  assign w_shamt = i_op_b[SHAMT_W-1:0];

  // Flipping the sign bits turns a signed compare into an unsigned one, so one comparator serves both.
  assign w_cmp_a = {i_op_a[DATA_W-1] ^ i_sig, i_op_a[DATA_W-2:0]};
  assign w_cmp_b = {i_op_b[DATA_W-1] ^ i_sig, i_op_b[DATA_W-2:0]};
  assign w_lt    = (w_cmp_a < w_cmp_b);

  assign w_acc_next = r_left ? {r_acc[DATA_W-2:0], 1'b0}
                             : {r_fill & r_acc[DATA_W-1], r_acc[DATA_W-1:1]};

  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = r_valid;
  assign o_result = r_result;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            case (i_func)
              2'b00, 2'b01: begin
                if (w_shamt != '0) begin
                  r_acc   <= i_op_a;
                  r_cnt   <= w_shamt;
                  r_left  <= (i_func == 2'b00);
                  r_fill  <= i_athi;
                  r_state <= S_SHIFT;
                end else begin
                  r_result <= i_op_a;
                  r_valid  <= 1'b1;
                  r_state  <= S_DONE;
                end
              end
              2'b10: begin
                r_result <= {{(DATA_W-1){1'b0}}, w_lt};
                r_valid  <= 1'b1;
                r_state  <= S_DONE;
              end
              default: begin
                r_result <= '0;
                r_valid  <= 1'b1;
                r_state  <= S_DONE;
              end
            endcase
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            r_result <= w_acc_next;
            r_valid  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
